// File: rtl/range_count_seq.sv
// range_count_seq
//   Programmable bounded up-counter sequencer. It takes a {lo, hi, passes}
//   configuration over a valid/ready handshake, then steps count from lo to hi
//   repeatedly until the requested number of passes completes (passes = 0
//   means run until aborted).
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   cfg_valid/ready     configuration handshake (ready only while idle)
//   cfg_lo, cfg_hi      first/last count value of each pass
//   cfg_passes          number of passes, 0 = continuous
//   pause, abort        hold the count / terminate the run (RUN only)
//   count, count_valid  current count, meaningful while running
//   wrap                one-cycle pulse on each hi->lo turnaround
//   done                one-cycle pulse after the final pass
//   err                 one-cycle pulse when a lo>hi configuration is rejected
//   busy                high while running or finishing
//
// Every output comes straight from a flop: the next value of each is formed
// in the combinational process and captured on the clock edge.
module range_count_seq #(
  parameter int WIDTH  = 4,
  parameter int PASS_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [WIDTH-1:0]  cfg_lo,
  input  logic [WIDTH-1:0]  cfg_hi,
  input  logic [PASS_W-1:0] cfg_passes,
  input  logic              pause,
  input  logic              abort,
  output logic [WIDTH-1:0]  count,
  output logic              count_valid,
  output logic              wrap,
  output logic              done,
  output logic              err,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    lo_q, lo_d;
  logic [WIDTH-1:0]    hi_q, hi_d;
  logic [PASS_W-1:0]   passes_q, passes_d;
  logic [PASS_W-1:0]   pass_cnt_q, pass_cnt_d;
  logic [PASS_W:0]     pass_nxt;
  logic                last_pass;

  logic [WIDTH-1:0]    count_d;
  logic                count_valid_d, wrap_d, done_d, err_d, busy_d, cfg_ready_d;

  // Pass counter compared one bit wider so pass_cnt+1 cannot alias to zero.
  always_comb begin
    pass_nxt  = {1'b0, pass_cnt_q} + {{PASS_W{1'b0}}, 1'b1};
    last_pass = (passes_q != '0) && (pass_nxt == {1'b0, passes_q});
  end

  always_comb begin
    state_d    = state_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    passes_d   = passes_q;
    pass_cnt_d = pass_cnt_q;
    count_d    = count;
    wrap_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (cfg_valid && cfg_ready) begin
          if (cfg_lo <= cfg_hi) begin
            lo_d       = cfg_lo;
            hi_d       = cfg_hi;
            passes_d   = cfg_passes;
            pass_cnt_d = '0;
            count_d    = cfg_lo;
            state_d    = RUN;
          end else begin
            // Rejected: stored bounds are left untouched.
            err_d = 1'b1;
          end
        end
      end

      RUN: begin
        if (abort) begin
          state_d = IDLE;
          count_d = '0;
        end else if (pause) begin
          // hold everything
        end else if (count < hi_q) begin
          // count < hi guarantees the increment cannot overflow WIDTH.
          count_d = count + {{(WIDTH-1){1'b0}}, 1'b1};
        end else if (last_pass) begin
          // Count holds hi through the DONE cycle.
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          // In continuous mode the pass counter wraps harmlessly.
          count_d    = lo_q;
          wrap_d     = 1'b1;
          pass_cnt_d = pass_nxt[PASS_W-1:0];
        end
      end

      DONE: begin
        state_d = IDLE;
        count_d = '0;
      end

      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase

    cfg_ready_d   = (state_d == IDLE);
    count_valid_d = (state_d == RUN);
    busy_d        = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lo_q        <= '0;
      hi_q        <= '0;
      passes_q    <= '0;
      pass_cnt_q  <= '0;
      count       <= '0;
      count_valid <= 1'b0;
      wrap        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      busy        <= 1'b0;
      cfg_ready   <= 1'b1;
    end else begin
      state_q     <= state_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      passes_q    <= passes_d;
      pass_cnt_q  <= pass_cnt_d;
      count       <= count_d;
      count_valid <= count_valid_d;
      wrap        <= wrap_d;
      done        <= done_d;
      err         <= err_d;
      busy        <= busy_d;
      cfg_ready   <= cfg_ready_d;
    end
  end

endmodule

// File: tb/tb_range_count_seq.sv
// Testbench for range_count_seq: directed table, hand-written corner
// sequences, then randomized stimulus against a queue-based reference model.
module tb_range_count_seq;

  localparam int W  = 4;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst, cfg_valid, cfg_ready, pause, abort;
  logic [W-1:0]  cfg_lo, cfg_hi, count;
  logic [PW-1:0] cfg_passes;
  logic          count_valid, wrap, done, err, busy;

  int vectors     = 0;
  int miscompares = 0;

  range_count_seq #(.WIDTH(W), .PASS_W(PW)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .cfg_passes(cfg_passes),
    .pause(pause), .abort(abort),
    .count(count), .count_valid(count_valid),
    .wrap(wrap), .done(done), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit r, v;
    logic [W-1:0] lo, hi;
    logic [PW-1:0] p;
    bit pz, ab;
    logic [W-1:0] c;
    bit cv, w, d, e, b, rd;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, v, input int lo, hi, p, input bit pz, ab,
                     input int c, input bit cv, w, d, e, b, rd);
    vec_t x;
    x.r = r; x.v = v; x.lo = W'(lo); x.hi = W'(hi); x.p = PW'(p);
    x.pz = pz; x.ab = ab; x.c = W'(c);
    x.cv = cv; x.w = w; x.d = d; x.e = e; x.b = b; x.rd = rd;
    tbl.push_back(x);
  endtask

  // Apply inputs, clock once, sample 1 time unit after the edge.
  task automatic cyc(input bit r, v, input int lo, hi, p, input bit pz, ab);
    rst = r; cfg_valid = v; cfg_lo = W'(lo); cfg_hi = W'(hi);
    cfg_passes = PW'(p); pause = pz; abort = ab;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [W-1:0] ec,
                       input bit ecv, ew, ed, ee, eb, erd);
    vectors++;
    if ({count, count_valid, wrap, done, err, busy, cfg_ready} !==
        {ec, ecv, ew, ed, ee, eb, erd}) begin
      miscompares++;
      $display("FAIL %s: got count=%0d cv=%b wrap=%b done=%b err=%b busy=%b rdy=%b, want count=%0d cv=%b wrap=%b done=%b err=%b busy=%b rdy=%b",
               name, count, count_valid, wrap, done, err, busy, cfg_ready,
               ec, ecv, ew, ed, ee, eb, erd);
    end
  endtask

  // ---------------- reference model: expected count stream as a queue ----
  typedef struct {int c; bit w;} ent_t;
  ent_t mq[$];
  int   m_mode = 0;   // 0 idle, 1 running, 2 finishing
  int   m_cur = 0, m_lo = 0, m_hi = 0;
  bit   m_cont = 0, m_wrap = 0, m_done = 0, m_err = 0;

  task automatic add_pass(input bit wrap_first);
    ent_t e;
    for (int x = m_lo; x <= m_hi; x++) begin
      e.c = x; e.w = wrap_first && (x == m_lo);
      mq.push_back(e);
    end
  endtask

  task automatic model_step(input bit r, v, input int lo, hi, p, input bit pz, ab);
    ent_t e;
    m_err = 0; m_done = 0; m_wrap = 0;
    if (r) begin
      m_mode = 0; mq.delete(); m_cur = 0;
    end else begin
      case (m_mode)
        0: if (v) begin
          if (lo <= hi) begin
            m_lo = lo; m_hi = hi; m_cont = (p == 0); mq.delete();
            if (m_cont) add_pass(1'b0);
            else for (int k = 0; k < p; k++) add_pass(k != 0);
            e = mq.pop_front(); m_cur = e.c; m_wrap = e.w; m_mode = 1;
          end else m_err = 1;
        end
        1: if (ab) begin
          m_mode = 0; mq.delete(); m_cur = 0;
        end else if (!pz) begin
          if (mq.size() == 0 && m_cont) add_pass(1'b1);
          if (mq.size() == 0) begin
            m_mode = 2; m_done = 1;
          end else begin
            e = mq.pop_front(); m_cur = e.c; m_wrap = e.w;
          end
        end
        default: begin
          m_mode = 0; m_cur = 0;
        end
      endcase
    end
  endtask

  initial begin
    rst = 1; cfg_valid = 0; cfg_lo = 0; cfg_hi = 0; cfg_passes = 0;
    pause = 0; abort = 0;

    // r v lo hi p pz ab | c cv w d e b rd
    add(1,0,0,0,0,0,0,   0,0,0,0,0,0,1);  // reset state
    add(0,1,3,5,2,0,0,   3,1,0,0,0,1,0);  // multi-pass with pause
    add(0,0,0,0,0,0,0,   4,1,0,0,0,1,0);
    add(0,0,0,0,0,1,0,   4,1,0,0,0,1,0);
    add(0,0,0,0,0,1,0,   4,1,0,0,0,1,0);
    add(0,0,0,0,0,0,0,   5,1,0,0,0,1,0);
    add(0,0,0,0,0,0,0,   3,1,1,0,0,1,0);
    add(0,0,0,0,0,0,0,   4,1,0,0,0,1,0);
    add(0,0,0,0,0,0,0,   5,1,0,0,0,1,0);
    add(0,0,0,0,0,0,0,   5,0,0,1,0,1,0);  // done, count holds hi
    add(0,0,0,0,0,0,0,   0,0,0,0,0,0,1);
    add(0,1,9,4,1,0,0,   0,0,0,0,1,0,1);  // illegal config -> err
    add(0,0,0,0,0,1,1,   0,0,0,0,0,0,1);  // pause/abort ignored in idle
    add(0,1,7,7,3,0,0,   7,1,0,0,0,1,0);  // degenerate lo==hi
    add(0,0,0,0,0,0,0,   7,1,1,0,0,1,0);
    add(0,0,0,0,0,0,0,   7,1,1,0,0,1,0);
    add(0,0,0,0,0,0,0,   7,0,0,1,0,1,0);
    add(0,1,1,2,1,0,1,   0,0,0,0,0,0,1);  // cfg/abort during DONE ignored
    add(0,1,2,3,1,0,0,   2,1,0,0,0,1,0);  // abort on final hi
    add(0,0,0,0,0,0,0,   3,1,0,0,0,1,0);
    add(0,0,0,0,0,0,1,   0,0,0,0,0,0,1);
    add(0,1,2,3,1,0,0,   2,1,0,0,0,1,0);  // pause at hi
    add(0,0,0,0,0,0,0,   3,1,0,0,0,1,0);
    add(0,0,0,0,0,1,0,   3,1,0,0,0,1,0);
    add(0,0,0,0,0,0,0,   3,0,0,1,0,1,0);
    add(0,0,0,0,0,0,0,   0,0,0,0,0,0,1);
    add(1,1,1,4,1,0,0,   0,0,0,0,0,0,1);  // reset beats handshake

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].r, tbl[i].v, int'(tbl[i].lo), int'(tbl[i].hi), int'(tbl[i].p),
          tbl[i].pz, tbl[i].ab);
      check($sformatf("table[%0d]", i), tbl[i].c, tbl[i].cv, tbl[i].w,
            tbl[i].d, tbl[i].e, tbl[i].b, tbl[i].rd);
    end

    // Single pass 3..12
    cyc(0,1,3,12,1,0,0);
    check("single_first", 3, 1,0,0,0,1,0);
    for (int k = 4; k <= 12; k++) begin
      cyc(0,0,0,0,0,0,0);
      check($sformatf("single_cnt%0d", k), W'(k), 1,0,0,0,1,0);
    end
    cyc(0,0,0,0,0,0,0);
    check("single_done", 12, 0,0,1,0,1,0);
    cyc(0,0,0,0,0,0,0);
    check("single_idle", 0, 0,0,0,0,0,1);

    // Reset mid-run at count=7
    cyc(0,1,0,15,0,0,0);
    for (int k = 1; k <= 7; k++) cyc(0,0,0,0,0,0,0);
    check("midrun_at7", 7, 1,0,0,0,1,0);
    cyc(1,0,0,0,0,0,0);
    check("midrun_reset", 0, 0,0,0,0,0,1);

    // Continuous full range, cfg_valid held with other bounds, abort at 6
    cyc(0,1,0,15,0,0,0);
    check("cont_k0", 0, 1,0,0,0,1,0);
    for (int k = 1; k <= 54; k++) begin
      cyc(0,1,5,6,1,0,0);
      check($sformatf("cont_k%0d", k), W'(k % 16), 1, (k % 16) == 0, 0,0,1,0);
    end
    cyc(0,0,0,0,0,0,1);
    check("cont_abort", 0, 0,0,0,0,0,1);

    // Randomized against the reference model
    cyc(1,0,0,0,0,0,0);
    model_step(1,0,0,0,0,0,0);
    check("rand_reset", 0, 0,0,0,0,0,1);
    for (int n = 0; n < 3000; n++) begin
      bit r, v, pz, ab;
      int lo, hi, p;
      r  = ($urandom_range(0,63) == 0);
      v  = ($urandom_range(0,3) == 0);
      lo = $urandom_range(0,15);
      hi = $urandom_range(0,15);
      p  = $urandom_range(0,3);
      pz = ($urandom_range(0,7) == 0);
      ab = ($urandom_range(0,31) == 0);
      cyc(r, v, lo, hi, p, pz, ab);
      model_step(r, v, lo, hi, p, pz, ab);
      check($sformatf("rand[%0d]", n), W'(m_cur), m_mode == 1, m_wrap, m_done,
            m_err, m_mode != 0, m_mode == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
